// File: rtl/spi_fnd_receiver.sv
// spi_fnd_receiver: SPI mode-0 slave that receives a two-byte counter frame, validates it
// and publishes the binary count and four BCD digits.
module spi_fnd_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sclk,
   input  logic        mosi,
   input  logic        ss,
   output logic [7:0]  num100,
   output logic [7:0]  num1,
   output logic [13:0] count_value,
   output logic [15:0] bcd,
   output logic        frame_valid,
   output logic        frame_err,
   output logic        busy
);
   typedef enum logic [1:0] {WAIT_IDLE, IDLE, RECV, CHECK} state_t;
   state_t state, state_next;
   logic [SYNC_STAGES:0] sclk_p, ss_p;
   logic [SYNC_STAGES-1:0] mosi_p;
   logic [15:0] sr;
   logic [4:0] bitcnt;
   logic [2:0] flush;
   logic sclk_rise, ss_s, ss_rise, ss_fall, mosi_s, flushed, good;
   logic [7:0] hi, lo;
   always_ff @(posedge clk) begin
      if (reset) begin
         sclk_p <= '0;
         mosi_p <= '0;
         ss_p   <= '1;
      end else begin
         sclk_p <= {sclk_p[SYNC_STAGES-1:0], sclk};
         mosi_p <= {mosi_p[SYNC_STAGES-2:0], mosi};
         ss_p   <= {ss_p[SYNC_STAGES-1:0], ss};
      end
   end
   assign sclk_rise = sclk_p[SYNC_STAGES-1] & ~sclk_p[SYNC_STAGES];
   assign ss_s      = ss_p[SYNC_STAGES-1];
   assign ss_rise   = ss_s & ~ss_p[SYNC_STAGES];
   assign ss_fall   = ~ss_s & ss_p[SYNC_STAGES];
   assign mosi_s    = mosi_p[SYNC_STAGES-1];
   // The synchronizer resets to ss=1, so wait until the real pin level has flushed through
   // before trusting ss; otherwise a reset released mid-frame would look like a fresh frame.
   assign flushed = flush == 3'(SYNC_STAGES + 1);
   always_ff @(posedge clk) begin
      if (reset) flush <= '0;
      else if (!flushed) flush <= flush + 3'd1;
   end
   always_ff @(posedge clk) begin
      if (reset) state <= WAIT_IDLE;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      busy = state == RECV;
      case (state)
         WAIT_IDLE: state_next = (flushed && ss_s) ? IDLE : WAIT_IDLE;
         IDLE:      state_next = ss_fall ? RECV : IDLE;
         RECV:      state_next = ss_rise ? CHECK : RECV;
         default:   state_next = IDLE;
      endcase
   end
   assign hi   = sr[15:8];
   assign lo   = sr[7:0];
   assign good = bitcnt == 5'd16 && hi <= 8'd99 && lo <= 8'd99;
   always_ff @(posedge clk) begin
      if (reset) begin
         sr          <= '0;
         bitcnt      <= '0;
         num100      <= '0;
         num1        <= '0;
         count_value <= '0;
         bcd         <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_valid <= state == CHECK && good;
         frame_err   <= state == CHECK && !good;
         if (state == IDLE && ss_fall) begin
            sr     <= '0;
            bitcnt <= '0;
         end else if (state == RECV && sclk_rise) begin
            sr     <= {sr[14:0], mosi_s};
            bitcnt <= (bitcnt == 5'd17) ? bitcnt : bitcnt + 5'd1;
         end
         if (state == CHECK && good) begin
            num100      <= hi;
            num1        <= lo;
            count_value <= 14'(hi) * 14'd100 + 14'(lo);
            bcd         <= {4'(hi / 8'd10), 4'(hi % 8'd10), 4'(lo / 8'd10), 4'(lo % 8'd10)};
         end
      end
   end
endmodule
